// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry constants,
// common to the transmitter and the 16x-oversampled receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int OVERSAMPLE_DEFAULT  = 16;
    localparam int WIDTH_DEFAULT       = 8;
    localparam int START_BITS          = 1;
    localparam int PARITY_BITS         = 1;
    localparam int STOP_BITS           = 1;
    localparam int FRAME_OVERHEAD_BITS = START_BITS + PARITY_BITS + STOP_BITS;

    // Clock cycles occupied by one complete frame on the line.
    function automatic int frame_cycles(input int width, input int oversample);
        return (width + FRAME_OVERHEAD_BITS) * oversample;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, WIDTH data bits LSB first, parity, stop; each bit
// held OVERSAMPLE clocks. A one-entry hold register allows gapless frames.
module uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEFAULT,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Tx_Data,
    input  logic             valid_tx,
    output logic             ready_tx,
    output logic             TxD,
    output logic             busy_tx,
    output logic             done_tx
);

    localparam int SCW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [SCW-1:0] SAMPLE_LAST = SCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BIT_LAST    = BCW'(WIDTH - 1);

    uart_state_t      state, state_n;
    logic [SCW-1:0]   sample_cnt, sample_cnt_n;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [BCW-1:0]   bit_next;
    logic [WIDTH-1:0] shift, shift_n;
    logic [WIDTH-1:0] hold, hold_n;
    logic             hold_full, hold_full_n;
    logic             parity_acc, parity_n;
    logic             txd_n;
    logic             done_n;
    logic             sample_last;
    logic             accept;

    assign ready_tx    = ~hold_full;
    assign busy_tx     = (state != IDLE);
    assign accept      = valid_tx & ready_tx;
    assign sample_last = (sample_cnt == SAMPLE_LAST);
    assign bit_next    = bit_cnt + 1'b1;

    always_comb begin
        state_n      = state;
        sample_cnt_n = sample_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        hold_n       = hold;
        hold_full_n  = hold_full;
        parity_n     = parity_acc;
        txd_n        = TxD;
        done_n       = 1'b0;

        if (state != IDLE) begin
            sample_cnt_n = sample_last ? '0 : sample_cnt + 1'b1;
            // A byte offered mid-frame parks in hold until the current stop bit ends.
            if (accept) begin
                hold_n      = Tx_Data;
                hold_full_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                txd_n        = 1'b1;
                sample_cnt_n = '0;
                bit_cnt_n    = '0;
                if (accept) begin
                    shift_n  = Tx_Data;
                    parity_n = 1'b0;
                    state_n  = START;
                    txd_n    = 1'b0;
                end else if (hold_full) begin
                    shift_n     = hold;
                    hold_full_n = 1'b0;
                    parity_n    = 1'b0;
                    state_n     = START;
                    txd_n       = 1'b0;
                end
            end

            START: begin
                txd_n = 1'b0;
                if (sample_last) begin
                    state_n   = DATA;
                    bit_cnt_n = '0;
                    txd_n     = shift[0];
                    parity_n  = parity_acc ^ shift[0];
                end
            end

            DATA: begin
                if (sample_last) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_n = PARITY;
                        txd_n   = parity_acc ^ PARITY_ODD;
                    end else begin
                        bit_cnt_n = bit_next;
                        txd_n     = shift[bit_next];
                        parity_n  = parity_acc ^ shift[bit_next];
                    end
                end
            end

            PARITY: begin
                if (sample_last) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end
            end

            STOP: begin
                txd_n = 1'b1;
                if (sample_last) begin
                    done_n = 1'b1;
                    // Drain hold straight into the next start bit: no idle cycle.
                    if (hold_full) begin
                        shift_n     = hold;
                        hold_full_n = 1'b0;
                        parity_n    = 1'b0;
                        state_n     = START;
                        txd_n       = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end

            default: begin
                state_n      = IDLE;
                txd_n        = 1'b1;
                sample_cnt_n = '0;
                bit_cnt_n    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sample_cnt <= '0;
            bit_cnt    <= '0;
            hold_full  <= 1'b0;
            parity_acc <= 1'b0;
            TxD        <= 1'b1;
            done_tx    <= 1'b0;
        end else begin
            state      <= state_n;
            sample_cnt <= sample_cnt_n;
            bit_cnt    <= bit_cnt_n;
            hold_full  <= hold_full_n;
            parity_acc <= parity_n;
            TxD        <= txd_n;
            done_tx    <= done_n;
        end
    end

    // Payload registers carry no reset; hold_full and state qualify them.
    always_ff @(posedge clk) begin
        shift <= shift_n;
        hold  <= hold_n;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the 16x-oversampled receiver already in the codebase. It sits on the same sample-rate clock, one TxD bit per 16 clk cycles. Each frame is start bit, WIDTH data bits LSB first, one parity bit, and one stop bit. A valid/ready byte interface feeds a one-entry holding register, so back-to-back frames go out with no idle gap.

Parameters:
WIDTH, 8, data bits per frame. The receiver supports 8 only; other values are for standalone use.
OVERSAMPLE, 16, clk cycles per serial bit. Must match the receiver.
PARITY_ODD, 0, 0 = even parity (XOR of the data bits), 1 = odd parity (inverted XOR).

Ports:
clk  in  1  sample-rate clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
Tx_Data  in  WIDTH  byte to send; sampled when valid_tx and ready_tx are both high
valid_tx  in  1  producer offers Tx_Data
ready_tx  out  1  combinational; equals NOT hold_full
TxD  out  1  registered serial line; idles high
busy_tx  out  1  high whenever the FSM is not in IDLE
done_tx  out  1  one-cycle pulse at the edge that completes a stop bit

Behaviour:
- Reset (rst high at an edge):
  - state becomes IDLE; TxD=1, done_tx=0, hold_full=0, counters=0.
  - ready_tx is 1 after the reset edge; valid_tx is ignored in any cycle where rst is high.
- States: IDLE, START, DATA, PARITY, STOP.
- sample_cnt (log2 OVERSAMPLE bits) counts 0..OVERSAMPLE-1 in every non-IDLE state.
- bit_cnt counts 0..WIDTH-1 in DATA.
- Accept: an edge where valid_tx=1 and ready_tx=1 (no rst).
  - If state is IDLE at that edge, the byte bypasses hold and goes straight into the shift register. State becomes START and TxD=0 from that edge.
  - Otherwise the byte goes into hold and hold_full becomes 1.
- IDLE: TxD=1. If hold_full=1, load from hold, clear hold_full, go to START, TxD=0.
- START: TxD=0 for OVERSAMPLE cycles. At sample_cnt=OVERSAMPLE-1, go to DATA and drive data bit 0.
- DATA:
  - TxD = shift[bit_cnt], each bit held OVERSAMPLE cycles.
  - Parity accumulator XORs each bit as it is driven.
  - After bit WIDTH-1 completes, go to PARITY.
- PARITY: TxD = accumulated XOR, inverted if PARITY_ODD. Held OVERSAMPLE cycles, then go to STOP.
- STOP: TxD=1 for OVERSAMPLE cycles. On the final edge, done_tx=1 for one cycle, then:
  - if hold_full=1, load from hold and go directly to START (no idle cycle);
  - else go to IDLE.
- Frame length is (WIDTH+3)*OVERSAMPLE cycles, i.e. 176 at the defaults. Consecutive start-bit falling edges are exactly 176 cycles apart when hold stays fed.
- Simultaneous events:
  - On the STOP-final edge with hold_full=1, ready_tx is 0, so any valid_tx is not accepted. Hold drains into the shifter and ready_tx rises after that edge.
  - Accept and hold-drain never collide, because accept requires hold_full=0.
- Tx_Data is sampled only at the accepting edge; later changes have no effect on the frame.
- Reset mid-frame aborts immediately: TxD=1 at the reset edge, hold is discarded, and no done_tx pulse is generated.
- Default branch of the case statement returns to IDLE with TxD=1.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4);
  - OVERSAMPLE_DEFAULT=16 and frame bit-count constants.
- The existing receiver should migrate to the same package.
- No sub-module: the parity XOR and the one-entry hold are small enough to live inline.

Test Plan:
- Idle check: after reset with no valid_tx for 100 cycles -> TxD=1, busy_tx=0, ready_tx=1, done_tx never pulses.
- Single frame: 0xA5 accepted while IDLE.
  - TxD sequence, 16 cycles per bit: 0 | 1,0,1,0,0,1,0,1 | 0 (even parity) | 1.
  - done_tx pulses at cycle 176 after acceptance; busy_tx falls then.
- Odd parity: PARITY_ODD=1, send 0x00 -> parity bit 1. With PARITY_ODD=0, send 0x01 -> parity bit 1.
- Back-to-back: 0x3C accepted while IDLE, then 0xC3 accepted next cycle into hold.
  - ready_tx=0 from then until the first stop bit ends.
  - Second start bit begins exactly 176 cycles after the first; two done_tx pulses 176 cycles apart.
- Loopback: TxD connected to UART_RX RxD, send 0x5A then 0xFF -> Rx_Data=0x5A then 0xFF, valid_rx pulses, parity_error=0, stop_error=0.
- Reset mid-frame: rst during DATA bit 3 with hold full -> TxD=1 at that edge, busy_tx=0, ready_tx=1. The next accepted byte 0x81 produces a clean full frame.
